csr_rmw_unit: RTL and testbench

//  Initiator side of the CSR read/write port: executes Zicsr instructions (CSRRW/S/C, CSRRWI/SI/CI)
//  as a sequenced read-modify-write against csr_regfile (combinational read, registered write).

---
 rtl/csr_rmw_if.sv | 28 ++
 rtl/csr_rmw_unit.sv | 136 +++++++++++++
 tb/tb_csr_rmw_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_rmw_if.sv
// Request/response channel between decode/execute and the CSR read-modify-write unit.
// master: the instruction issuer (drives req_*, resp_ready).
// slave : csr_rmw_unit (drives req_ready, resp_*).
interface csr_rmw_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [CSR_ADDR_W-1:0] req_csr_addr;
  logic [XLEN-1:0]       req_rs1_data;
  logic [4:0]            req_rs1_idx;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [XLEN-1:0]       resp_rd_data;
  logic                  resp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, resp_ready,
    input  req_ready, resp_valid, resp_rd_data, resp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, resp_ready,
    output req_ready, resp_valid, resp_rd_data, resp_illegal
  );
endinterface

// File: rtl/csr_rmw_unit.sv
// Sequenced read-modify-write engine for Zicsr instructions against csr_regfile.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   rif            request/response channel (slave side)
//   csr_addr       address to csr_regfile (held outside READ/WRITE)
//   csr_w_data     write data to csr_regfile (held outside WRITE)
//   csr_w_en       write strobe, high only during WRITE
//   csr_r_data     combinational read data from csr_regfile
module csr_rmw_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  csr_rmw_if.slave              rif,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_w_data,
  output logic                  csr_w_en,
  input  logic [XLEN-1:0]       csr_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t                state, state_d;
  logic [2:0]            op_f3, op_f3_d;
  logic [XLEN-1:0]       op_src, op_src_d;
  logic                  op_wr, op_wr_d;
  logic [CSR_ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]       wdata_d;
  logic                  wen_d;
  logic                  rvalid_d;
  logic                  ill_d;
  logic [XLEN-1:0]       rd_d;
  logic                  accept;

  // Only the implemented machine-mode CSRs are reachable.
  function automatic logic is_legal_addr(input logic [CSR_ADDR_W-1:0] a);
    case (a)
      CSR_ADDR_W'('h300), CSR_ADDR_W'('h304), CSR_ADDR_W'('h305),
      CSR_ADDR_W'('h340), CSR_ADDR_W'('h341), CSR_ADDR_W'('h342),
      CSR_ADDR_W'('h343), CSR_ADDR_W'('h344): is_legal_addr = 1'b1;
      default:                                is_legal_addr = 1'b0;
    endcase
  endfunction

  assign rif.req_ready = (state == S_IDLE);
  assign accept        = rif.req_valid & rif.req_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    op_f3_d  = op_f3;
    op_src_d = op_src;
    op_wr_d  = op_wr;
    addr_d   = csr_addr;
    wdata_d  = csr_w_data;
    wen_d    = 1'b0;
    rvalid_d = rif.resp_valid;
    ill_d    = rif.resp_illegal;
    rd_d     = rif.resp_rd_data;

    case (state)
      S_IDLE: begin
        if (accept) begin
          op_f3_d  = rif.req_funct3;
          op_src_d = rif.req_funct3[2] ? XLEN'(rif.req_rs1_idx) : rif.req_rs1_data;
          // Set/clear forms with rs1/zimm == 0 are pure reads.
          op_wr_d  = (rif.req_funct3[1:0] == 2'b01) || (rif.req_rs1_idx != 5'd0);
          if (is_legal_addr(rif.req_csr_addr) && (rif.req_funct3[1:0] != 2'b00)) begin
            addr_d  = rif.req_csr_addr;
            state_d = S_READ;
          end else begin
            rvalid_d = 1'b1;
            ill_d    = 1'b1;
            rd_d     = '0;
            state_d  = S_RESP;
          end
        end
      end
      S_READ: begin
        // Capture the old value and precompute the write so csr_w_data is stable through WRITE.
        rd_d  = csr_r_data;
        ill_d = 1'b0;
        wen_d = op_wr;
        if (op_wr) begin
          case (op_f3[1:0])
            2'b10:   wdata_d = csr_r_data | op_src;
            2'b11:   wdata_d = csr_r_data & ~op_src;
            default: wdata_d = op_src;
          endcase
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rvalid_d = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rif.resp_ready) begin
          rvalid_d = 1'b0;
          ill_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      op_f3            <= 3'd0;
      op_src           <= '0;
      op_wr            <= 1'b0;
      csr_addr         <= '0;
      csr_w_data       <= '0;
      csr_w_en         <= 1'b0;
      rif.resp_valid   <= 1'b0;
      rif.resp_illegal <= 1'b0;
      rif.resp_rd_data <= '0;
    end else begin
      state            <= state_d;
      op_f3            <= op_f3_d;
      op_src           <= op_src_d;
      op_wr            <= op_wr_d;
      csr_addr         <= addr_d;
      csr_w_data       <= wdata_d;
      csr_w_en         <= wen_d;
      rif.resp_valid   <= rvalid_d;
      rif.resp_illegal <= ill_d;
      rif.resp_rd_data <= rd_d;
    end
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Scoreboard bench for csr_rmw_unit with a behavioural csr_regfile.
module tb_csr_rmw_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] csr_addr;
  logic [31:0] csr_w_data;
  logic        csr_w_en;
  logic [31:0] csr_r_data;

  csr_rmw_if #(.XLEN(32), .CSR_ADDR_W(12)) rif ();

  csr_rmw_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .rif        (rif.slave),
    .csr_addr   (csr_addr),
    .csr_w_data (csr_w_data),
    .csr_w_en   (csr_w_en),
    .csr_r_data (csr_r_data)
  );

  always #5 clock = ~clock;

  // Behavioural regfile: combinational read, registered write, plus a preload port.
  logic [31:0] regs [4096];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  assign csr_r_data = regs[csr_addr];
  always @(posedge clock) begin
    if (pre_en)        regs[pre_addr] <= pre_data;
    else if (csr_w_en) regs[csr_addr] <= csr_w_data;
  end

  typedef struct { logic [31:0] rd; logic ill; } resp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every response handshake is matched against the queues.
  always @(negedge clock) begin
    if (csr_w_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_w_en", 32'(csr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("w_addr", 32'(csr_addr), 32'(w.addr));
        check("w_data", csr_w_data, w.data);
      end
    end
    if (rif.resp_valid === 1'b1 && rif.resp_ready === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", rif.resp_rd_data, 32'hFFFF_FFFF);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_rd_data", rif.resp_rd_data, r.rd);
        check("resp_illegal", 32'(rif.resp_illegal), 32'(r.ill));
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic ill);
    resp_t r;
    r.rd = rd; r.ill = ill;
    resp_q.push_back(r);
  endtask

  task automatic exp_write(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Drives a request until accepted; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                       input logic [4:0] idx);
    int n;
    @(negedge clock);
    rif.req_valid = 1'b1; rif.req_funct3 = f3; rif.req_csr_addr = a;
    rif.req_rs1_data = d; rif.req_rs1_idx = idx;
    n = 0;
    while (rif.req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clock);
    #1;
    rif.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || rif.req_ready !== 1'b1) && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 50) check("drain_timeout", 32'(resp_q.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rif.req_valid = 1'b0; rif.req_funct3 = 3'd0; rif.req_csr_addr = '0;
    rif.req_rs1_data = '0; rif.req_rs1_idx = '0; rif.resp_ready = 1'b1;

    repeat (2) step();
    check("rst_req_ready", 32'(rif.req_ready), 32'd1);
    check("rst_resp_valid", 32'(rif.resp_valid), 32'd0);
    check("rst_resp_illegal", 32'(rif.resp_illegal), 32'd0);
    check("rst_resp_rd", rif.resp_rd_data, 32'd0);
    check("rst_w_en", 32'(csr_w_en), 32'd0);
    check("rst_addr", 32'(csr_addr), 32'd0);
    check("rst_w_data", csr_w_data, 32'd0);

    preload(12'h340, 32'h1234_5678);
    preload(12'h300, 32'h0000_00F0);
    preload(12'h305, 32'h8000_0000);
    preload(12'h341, 32'h0000_0000);
    preload(12'h342, 32'h0000_0000);
    preload(12'h304, 32'h0000_0000);
    preload(12'h000, 32'h0000_0000);
    @(negedge clock);
    reset = 1'b0;

    // 1: CSRRW with cycle-exact latency checks
    exp_write(12'h340, 32'hDEAD_BEEF);
    exp_resp(32'h1234_5678, 1'b0);
    issue(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd1);
    check("t1_c1_w_en", 32'(csr_w_en), 32'd0);
    check("t1_c1_addr", 32'(csr_addr), 32'h340);
    check("t1_c1_req_ready", 32'(rif.req_ready), 32'd0);
    step();
    check("t1_c2_w_en", 32'(csr_w_en), 32'd1);
    check("t1_c2_w_data", csr_w_data, 32'hDEAD_BEEF);
    check("t1_c2_resp_valid", 32'(rif.resp_valid), 32'd0);
    step();
    check("t1_c3_w_en", 32'(csr_w_en), 32'd0);
    check("t1_c3_resp_valid", 32'(rif.resp_valid), 32'd1);
    check("t1_c3_rd", rif.resp_rd_data, 32'h1234_5678);
    step();
    check("t1_c4_req_ready", 32'(rif.req_ready), 32'd1);
    check("t1_c4_resp_valid", 32'(rif.resp_valid), 32'd0);
    check("t1_c4_addr_held", 32'(csr_addr), 32'h340);
    check("t1_c4_data_held", csr_w_data, 32'hDEAD_BEEF);

    // 2: set with rs1_idx=0 is read-only; clear writes F0 & ~30 = C0
    exp_resp(32'h0000_00F0, 1'b0);
    issue(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0);
    drain();
    exp_write(12'h300, 32'h0000_00C0);
    exp_resp(32'h0000_00F0, 1'b0);
    issue(3'b011, 12'h300, 32'h0000_0030, 5'd6);
    drain();
    exp_resp(32'h0000_00C0, 1'b0);
    issue(3'b010, 12'h300, 32'h0000_0000, 5'd0);
    drain();

    // 3: immediate forms, zimm zero-extended
    exp_write(12'h305, 32'h0000_001F);
    exp_resp(32'h8000_0000, 1'b0);
    issue(3'b101, 12'h305, 32'hFFFF_FFFF, 5'h1F);
    drain();
    exp_resp(32'h0000_001F, 1'b0);
    issue(3'b110, 12'h305, 32'hFFFF_FFFF, 5'd0);
    drain();
    exp_write(12'h305, 32'h0000_001C);
    exp_resp(32'h0000_001F, 1'b0);
    issue(3'b111, 12'h305, 32'hFFFF_FFFF, 5'd3);
    drain();
    exp_write(12'h304, 32'h0000_0880);
    exp_resp(32'h0000_0000, 1'b0);
    issue(3'b010, 12'h304, 32'h0000_0880, 5'd9);
    drain();

    // 4: illegal address and illegal funct3, response one cycle after accept
    exp_resp(32'h0000_0000, 1'b1);
    issue(3'b001, 12'h7C0, 32'h5555_5555, 5'd2);
    check("t4_c1_resp_valid", 32'(rif.resp_valid), 32'd1);
    check("t4_c1_illegal", 32'(rif.resp_illegal), 32'd1);
    check("t4_c1_addr_held", 32'(csr_addr), 32'h304);
    drain();
    exp_resp(32'h0000_0000, 1'b1);
    issue(3'b100, 12'h300, 32'h5555_5555, 5'd2);
    drain();
    check("t4_after_illegal", 32'(rif.resp_illegal), 32'd0);

    // 5: back-pressure holds the response stable
    rif.resp_ready = 1'b0;
    exp_write(12'h341, 32'hAAAA_5555);
    exp_resp(32'h0000_0000, 1'b0);
    issue(3'b001, 12'h341, 32'hAAAA_5555, 5'd4);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check("t5_resp_valid_held", 32'(rif.resp_valid), 32'd1);
      check("t5_rd_held", rif.resp_rd_data, 32'h0000_0000);
      check("t5_req_ready_low", 32'(rif.req_ready), 32'd0);
      step();
    end
    @(negedge clock);
    rif.resp_ready = 1'b1;
    step();
    check("t5_resp_dropped", 32'(rif.resp_valid), 32'd0);
    check("t5_req_ready", 32'(rif.req_ready), 32'd1);

    // 6: reset during WRITE drops the operation (the regfile still takes the strobe already high)
    exp_write(12'h342, 32'h1111_2222);
    issue(3'b001, 12'h342, 32'h1111_2222, 5'd8);
    step();
    reset = 1'b1;
    step();
    check("t6_w_en", 32'(csr_w_en), 32'd0);
    check("t6_req_ready", 32'(rif.req_ready), 32'd1);
    check("t6_resp_valid", 32'(rif.resp_valid), 32'd0);
    check("t6_addr_rst", 32'(csr_addr), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(); step();
    check("t6_no_resp", 32'(rif.resp_valid), 32'd0);
    exp_write(12'h342, 32'h1111_2223);
    exp_resp(32'h1111_2222, 1'b0);
    issue(3'b110, 12'h342, 32'h0, 5'd1);
    drain();

    repeat (3) step();
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
